// File: rtl/notch_tone_gen.sv
// Recursive unit-circle resonator streaming a test tone over valid/ready, re-seeded every RESYNC_LEN samples.
// Define TONE_GEN_SAT_EN to saturate the recurrence result; otherwise it wraps to WIDTH bits.
module notch_tone_gen #(
  parameter int unsigned              WIDTH      = 16,
  parameter int unsigned              COEF_W     = 18,
  parameter int unsigned              FRAC       = 14,
  parameter logic signed [COEF_W-1:0] COEF       = '0,
  parameter logic signed [WIDTH-1:0]  SEED       = WIDTH'(8192),
  parameter int unsigned              RESYNC_LEN = 8
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_valid,
  output logic                    busy
);

  localparam int unsigned ProdW = WIDTH + COEF_W;
  localparam int unsigned SumW  = WIDTH + 2;
  localparam int unsigned CntW  = $clog2(RESYNC_LEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(RESYNC_LEN - 1);

  typedef enum logic [1:0] {StIdle, StSeed, StRun} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic signed [WIDTH-1:0] y1_q, y1_d, y2_q, y2_d, y_out_q, y_out_d;
  logic                    valid_q, valid_d, busy_q;

  logic signed [ProdW-1:0] prod;
  logic signed [SumW-1:0]  sum;
  logic signed [WIDTH-1:0] next_y;
  logic                    accept;

  // Next recurrence sample from the current history.
  always_comb begin
    prod = ProdW'(COEF) * ProdW'(y1_q);
    sum  = SumW'(prod >>> FRAC) - SumW'(y2_q);
`ifdef TONE_GEN_SAT_EN
    if (sum[SumW-1:WIDTH-1] == {(SumW-WIDTH+1){1'b0}} ||
        sum[SumW-1:WIDTH-1] == {(SumW-WIDTH+1){1'b1}}) begin
      next_y = sum[WIDTH-1:0];
    end else if (sum[SumW-1]) begin
      next_y = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      next_y = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    next_y = WIDTH'(sum);
`endif
  end

  assign accept = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y_out_d = y_out_q;
    valid_d = valid_q;
    if (state_q != StIdle && stop) begin
      // stop wins over a same-cycle accept; the presented sample is dropped
      state_d = StIdle;
      cnt_d   = '0;
      y1_d    = '0;
      y2_d    = '0;
      y_out_d = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !stop) begin
            state_d = StSeed;
            cnt_d   = '0;
            y1_d    = '0;
            y2_d    = '0;
            y_out_d = '0;
            valid_d = 1'b1;
          end
        end
        StSeed: begin
          if (accept) begin
            state_d = StRun;
            cnt_d   = CntW'(1);
            y1_d    = SEED;
            y2_d    = '0;
            y_out_d = SEED;
          end
        end
        StRun: begin
          if (accept) begin
            if (cnt_q == LastCnt) begin
              state_d = StSeed;
              cnt_d   = '0;
              y1_d    = '0;
              y2_d    = '0;
              y_out_d = '0;
            end else begin
              cnt_d   = cnt_q + CntW'(1);
              y2_d    = y1_q;
              y1_d    = next_y;
              y_out_d = next_y;
            end
          end
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y_out_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y_out_q <= y_out_d;
      valid_q <= valid_d;
      busy_q  <= (state_d != StIdle);
    end
  end

  assign y_out   = y_out_q;
  assign y_valid = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_notch_tone_gen.sv
// Directed bench: three resonator instances (pi/2, pi/3, overflow) checked against hand-computed tables.
module tb_notch_tone_gen;

  logic              clk;
  logic              rst_n;
  logic [2:0]        start, stop, rdy, valid, busy;
  logic signed [15:0] y [3];

  int checks = 0;
  int errors = 0;

  logic signed [15:0] exp_pi2 [8] = '{16'sd0, 16'sd8192, 16'sd0, -16'sd8192,
                                       16'sd0, 16'sd8192, 16'sd0, -16'sd8192};
  logic signed [15:0] exp_pi3 [6] = '{16'sd0, 16'sd8192, 16'sd8192, 16'sd0,
                                       -16'sd8192, -16'sd8192};
`ifdef TONE_GEN_SAT_EN
  localparam logic signed [15:0] OvfY2 = 16'sd32767;
`else
  localparam logic signed [15:0] OvfY2 = -16'sd4;
`endif

  notch_tone_gen #(.COEF(18'sd0), .SEED(16'sd8192), .RESYNC_LEN(8)) u_pi2 (
    .CLK(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .out_ready(rdy[0]),
    .y_out(y[0]), .y_valid(valid[0]), .busy(busy[0]));

  notch_tone_gen #(.COEF(18'sd16384), .SEED(16'sd8192), .RESYNC_LEN(6)) u_pi3 (
    .CLK(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .out_ready(rdy[1]),
    .y_out(y[1]), .y_valid(valid[1]), .busy(busy[1]));

  notch_tone_gen #(.COEF(18'sd32767), .SEED(16'sd32767), .RESYNC_LEN(8)) u_ovf (
    .CLK(clk), .rst_n(rst_n), .start(start[2]), .stop(stop[2]), .out_ready(rdy[2]),
    .y_out(y[2]), .y_valid(valid[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (y[i] !== 16'sd0 || valid[i] !== 1'b0 || busy[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: got y=%0d v=%b b=%b, expected y=0 v=0 b=0",
                 i, y[i], valid[i], busy[i]);
      end
    end
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got v=%b b=%b, expected 0 0", valid[0], busy[0]);
    end
  endtask

  task automatic test_pi2();
    rdy[0] = 1'b1;
    pulse_start(0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (y[0] !== exp_pi2[k % 8] || valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL pi2 k=%0d: got y=%0d v=%b, expected y=%0d v=1",
                 k, y[0], valid[0], exp_pi2[k % 8]);
      end
      start[0] = (k == 4);  // start while busy must be ignored
      step();
    end
    start[0] = 1'b0;
    stop[0]  = 1'b1;
    step();
    stop[0]  = 1'b0;
  endtask

  task automatic test_pi3();
    rdy[1] = 1'b1;
    pulse_start(1);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (y[1] !== exp_pi3[k % 6] || valid[1] !== 1'b1 || busy[1] !== 1'b1) begin
        errors++;
        $display("FAIL pi3 k=%0d: got y=%0d v=%b b=%b, expected y=%0d v=1 b=1",
                 k, y[1], valid[1], busy[1], exp_pi3[k % 6]);
      end
      step();
    end
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    rdy[1] = 1'b1;
    pulse_start(1);
    step();
    step();
    rdy[1] = 1'b0;
    for (int h = 0; h < 3; h++) begin
      step();
      checks++;
      if (y[1] !== 16'sd8192 || valid[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold h=%0d: got y=%0d v=%b, expected y=8192 v=1", h, y[1], valid[1]);
      end
    end
    rdy[1] = 1'b1;
    for (int k = 2; k < 10; k++) begin
      checks++;
      if (y[1] !== exp_pi3[k % 6] || valid[1] !== 1'b1) begin
        errors++;
        $display("FAIL bp_resume k=%0d: got y=%0d v=%b, expected y=%0d v=1",
                 k, y[1], valid[1], exp_pi3[k % 6]);
      end
      step();
    end
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
  endtask

  task automatic test_stop();
    rdy[0] = 1'b1;
    pulse_start(0);
    step();
    step();
    step();
    checks++;
    if (y[0] !== -16'sd8192) begin
      errors++;
      $display("FAIL stop_pre k=3: got y=%0d, expected -8192", y[0]);
    end
    stop[0] = 1'b1;
    step();
    stop[0] = 1'b0;
    checks++;
    if (y[0] !== 16'sd0 || valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL stop: got y=%0d v=%b b=%b, expected y=0 v=0 b=0", y[0], valid[0], busy[0]);
    end
    pulse_start(0);
    checks++;
    if (y[0] !== 16'sd0 || valid[0] !== 1'b1 || busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart y0: got y=%0d v=%b b=%b, expected y=0 v=1 b=1",
               y[0], valid[0], busy[0]);
    end
    step();
    checks++;
    if (y[0] !== 16'sd8192) begin
      errors++;
      $display("FAIL restart y1: got y=%0d, expected 8192", y[0]);
    end
    stop[0] = 1'b1;
    step();
    // start and stop together in idle must stay idle
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    stop[0]  = 1'b0;
    checks++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_idle: got v=%b b=%b, expected 0 0", valid[0], busy[0]);
    end
  endtask

  task automatic test_async_reset();
    rdy[0] = 1'b1;
    pulse_start(0);
    step();
    step();
    step();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (y[0] !== 16'sd0 || valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got y=%0d v=%b b=%b, expected y=0 v=0 b=0",
               y[0], valid[0], busy[0]);
    end
    #2 rst_n = 1'b1;
    step();
    step();
    checks++;
    if (valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got v=%b b=%b, expected 0 0", valid[0], busy[0]);
    end
  endtask

  task automatic test_overflow();
    rdy[2] = 1'b1;
    pulse_start(2);
    step();
    checks++;
    if (y[2] !== 16'sd32767) begin
      errors++;
      $display("FAIL ovf y1: got %0d, expected 32767", y[2]);
    end
    step();
    checks++;
    if (y[2] !== OvfY2) begin
      errors++;
      $display("FAIL ovf y2: got %0d, expected %0d", y[2], OvfY2);
    end
    stop[2] = 1'b1;
    step();
    stop[2] = 1'b0;
  endtask

  initial begin
    start = '0;
    stop  = '0;
    rdy   = '0;
    rst_n = 1'b0;
    test_reset();
    test_pi2();
    test_pi3();
    test_backpressure();
    test_stop();
    test_async_reset();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
